// File: rtl/interp_row_fir4_if.sv
// interp_row_fir4_if: config, input-sample and output-sample handshake bundle
interface interp_row_fir4_if #(
    parameter int DW = 8,
    parameter int CW = 8
);
    logic            cfg_load;
    logic [4*CW-1:0] cfg_coef;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    modport master (
        output cfg_load, cfg_coef, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  cfg_load, cfg_coef, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/interp_row_fir4.sv
// interp_row_fir4: streaming 4-tap row interpolator with edge replication and registered output
module interp_row_fir4 #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    interp_row_fir4_if.slave s
);
    localparam int SW = DW + CW + 3;
    localparam logic signed [SW-1:0] RND  = SW'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << DW) - 1);
    typedef enum logic [2:0] {IDLE, FILL1, FILL2, RUN, FLUSH} state_t;
    state_t                state;
    logic [DW-1:0]         w [4];
    logic [DW-1:0]         nw [4];
    logic [4*CW-1:0]       coef;
    logic [1:0]            flush_cnt;
    logic                  adv, acc, step, emit, ld, shift_en;
    logic [DW-1:0]         shin, yc, od;
    logic signed [SW-1:0]  sum, sh;
    logic                  ov, ol;
    assign adv        = !ov || s.out_ready;
    assign s.in_ready = state != FLUSH && adv;
    assign acc        = s.in_valid && s.in_ready;
    assign step       = state == FLUSH && adv;
    assign emit       = step || (acc && (state == FILL2 || state == RUN));
    assign ld         = acc && state == IDLE;
    assign shift_en   = acc || step;
    assign shin       = step ? w[3] : s.in_data;
    assign s.out_valid = ov;
    assign s.out_data  = od;
    assign s.out_last  = ol;
    // next window (x0 fills all taps, later samples shift in) and its filtered, rounded, clipped result
    always_comb begin
        nw[0] = ld ? s.in_data : shift_en ? w[1] : w[0];
        nw[1] = ld ? s.in_data : shift_en ? w[2] : w[1];
        nw[2] = ld ? s.in_data : shift_en ? w[3] : w[2];
        nw[3] = ld ? s.in_data : shift_en ? shin : w[3];
        sum = RND;
        for (int j = 0; j < 4; j++)
            sum = sum + SW'($signed({1'b0, nw[j]})) * SW'($signed(coef[j*CW +: CW]));
        sh = sum >>> SHIFT;
        yc = sh[SW-1] ? '0 : sh > MAXV ? '1 : sh[DW-1:0];
    end
    // row sequencing, window/coefficient state and the registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            w         <= '{default: '0};
            flush_cnt <= '0;
            ov        <= 1'b0;
            od        <= '0;
            ol        <= 1'b0;
            coef      <= (4*CW)'(1) << (CW + SHIFT);
        end else begin
            w <= nw;
            if (state == IDLE && s.cfg_load) coef <= s.cfg_coef;
            if (emit) begin
                ov <= 1'b1;
                od <= yc;
                ol <= step && flush_cnt == 2'd1;
            end else if (s.out_ready) ov <= 1'b0;
            if (acc) begin
                state <= s.in_last ? FLUSH : state == IDLE ? FILL1 : state == FILL1 ? FILL2 : RUN;
                if (s.in_last) flush_cnt <= state == IDLE ? 2'd1 : 2'd2;
            end else if (step) begin
                flush_cnt <= flush_cnt - 2'd1;
                if (flush_cnt == 2'd1) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_interp_row_fir4.sv
// tb_interp_row_fir4: directed scenarios for the row interpolator
module tb_interp_row_fir4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    interp_row_fir4_if bus ();
    interp_row_fir4 dut (.clk(clk), .rst_n(rst_n), .s(bus));
    localparam logic [31:0] ID  = {8'h00, 8'h00, 8'h40, 8'h00};
    localparam logic [31:0] HP  = {8'hFC, 8'h24, 8'h24, 8'hFC};
    localparam logic [31:0] C4A = {8'h00, 8'hE0, 8'h60, 8'h00};
    localparam logic [31:0] C4B = {8'h00, 8'h60, 8'hE0, 8'h00};
    int checks = 0;
    int failures = 0;
    logic [7:0] smp [64];
    logic       lst [64];
    logic [7:0] got [64];
    logic       got_last [64];
    int         got_cyc [64];
    int n_in, n_out, n_got;
    int stall_at = -1;
    int mid_cfg_at = -1;
    logic do_load = 1'b0;
    logic [31:0] new_coef = ID;
    int hold_bad, ready_bad, stall_cyc;
    task automatic run_row();
        int cyc, stall_left, t;
        logic held_set;
        logic [7:0] held;
        for (int i = 0; i < 64; i++) begin
            got[i] = 'x;
            got_last[i] = 1'bx;
        end
        n_got = 0;
        hold_bad = 0;
        ready_bad = 0;
        stall_cyc = 0;
        held_set = 1'b0;
        held = '0;
        cyc = 0;
        stall_left = 5;
        fork
            begin
                for (int i = 0; i < n_in; i++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = smp[i];
                    bus.in_last  = lst[i];
                    bus.cfg_load = (i == 0 && do_load) || i == mid_cfg_at;
                    bus.cfg_coef = i == 0 ? new_coef : ID;
                    t = 0;
                    @(negedge clk);
                    while (!bus.in_ready && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                bus.cfg_load = 1'b0;
            end
            begin
                bus.out_ready = 1'b1;
                while (n_got < n_out && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.out_valid && bus.out_ready) begin
                        got[n_got] = bus.out_data;
                        got_last[n_got] = bus.out_last;
                        got_cyc[n_got] = cyc;
                        n_got++;
                    end else if (bus.out_valid && !bus.out_ready) begin
                        if (!held_set) begin
                            held = bus.out_data;
                            held_set = 1'b1;
                        end else if (bus.out_data !== held) hold_bad++;
                        if (bus.in_ready) ready_bad++;
                        stall_cyc++;
                    end
                    @(posedge clk);
                    #1;
                    bus.out_ready = !(stall_at >= 0 && n_got == stall_at && stall_left > 0);
                    if (!bus.out_ready) stall_left--;
                end
                bus.out_ready = 1'b1;
            end
        join
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got %0d expected 0", bus.out_data); end
        checks++;
        if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got %b expected 0", bus.out_last); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask
    task automatic test_identity();
        for (int i = 0; i < 10; i++) begin
            smp[i] = 8'(i);
            lst[i] = i == 9;
        end
        n_in = 10;
        n_out = 10;
        do_load = 1'b0;
        run_row();
        checks++;
        if (n_got !== 10) begin failures++; $display("FAIL identity_count got %0d expected 10", n_got); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== 8'(i) || got_last[i] !== (i == 9)) begin
                failures++;
                $display("FAIL identity[%0d] got %0d/%b expected %0d/%b", i, got[i], got_last[i], i, i == 9);
            end
        end
    endtask
    task automatic test_half_pel();
        logic [7:0] exp_v [4];
        exp_v = '{8'd14, 8'd25, 8'd36, 8'd41};
        smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd40;
        for (int i = 0; i < 4; i++) lst[i] = i == 3;
        n_in = 4;
        n_out = 4;
        do_load = 1'b1;
        new_coef = HP;
        run_row();
        checks++;
        if (n_got !== 4) begin failures++; $display("FAIL half_pel_count got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_v[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL half_pel[%0d] got %0d/%b expected %0d/%b", i, got[i], got_last[i], exp_v[i], i == 3);
            end
        end
    endtask
    task automatic test_back_to_back();
        smp[0] = 8'd100; lst[0] = 1'b1;
        smp[1] = 8'd50;  lst[1] = 1'b1;
        n_in = 2;
        n_out = 2;
        do_load = 1'b0;
        run_row();
        checks++;
        if (got[0] !== 8'd100 || got_last[0] !== 1'b1) begin failures++; $display("FAIL b2b_first got %0d/%b expected 100/1", got[0], got_last[0]); end
        checks++;
        if (got[1] !== 8'd50 || got_last[1] !== 1'b1) begin failures++; $display("FAIL b2b_second got %0d/%b expected 50/1", got[1], got_last[1]); end
        checks++;
        if (got_cyc[1] - got_cyc[0] !== 2) begin failures++; $display("FAIL b2b_gap got %0d expected 2", got_cyc[1] - got_cyc[0]); end
    endtask
    task automatic test_clip();
        smp[0] = 8'd0; smp[1] = 8'd255; lst[0] = 1'b0; lst[1] = 1'b1;
        n_in = 2;
        n_out = 2;
        do_load = 1'b1;
        new_coef = C4A;
        run_row();
        checks++;
        if (got[0] !== 8'd0) begin failures++; $display("FAIL clip_low got %0d expected 0", got[0]); end
        checks++;
        if (got[1] !== 8'd255 || got_last[1] !== 1'b1) begin failures++; $display("FAIL clip_low_tail got %0d/%b expected 255/1", got[1], got_last[1]); end
        smp[0] = 8'd255;
        new_coef = C4B;
        run_row();
        checks++;
        if (got[0] !== 8'd255 || got_last[0] !== 1'b0) begin failures++; $display("FAIL clip_high0 got %0d/%b expected 255/0", got[0], got_last[0]); end
        checks++;
        if (got[1] !== 8'd255 || got_last[1] !== 1'b1) begin failures++; $display("FAIL clip_high1 got %0d/%b expected 255/1", got[1], got_last[1]); end
    endtask
    task automatic test_stall();
        logic [7:0] e;
        for (int i = 0; i < 20; i++) begin
            smp[i] = 8'(i);
            lst[i] = i == 19;
        end
        n_in = 20;
        n_out = 20;
        do_load = 1'b1;
        new_coef = HP;
        stall_at = 8;
        mid_cfg_at = 10;
        run_row();
        stall_at = -1;
        mid_cfg_at = -1;
        checks++;
        if (n_got !== 20) begin failures++; $display("FAIL stall_count got %0d expected 20", n_got); end
        checks++;
        if (stall_cyc !== 5) begin failures++; $display("FAIL stall_cycles got %0d expected 5", stall_cyc); end
        checks++;
        if (hold_bad !== 0) begin failures++; $display("FAIL stall_hold got %0d changes expected 0", hold_bad); end
        checks++;
        if (ready_bad !== 0) begin failures++; $display("FAIL stall_in_ready got %0d high cycles expected 0", ready_bad); end
        for (int i = 0; i < 20; i++) begin
            e = i == 0 ? 8'd0 : i >= 18 ? 8'd19 : 8'(i + 1);
            checks++;
            if (got[i] !== e || got_last[i] !== (i == 19)) begin
                failures++;
                $display("FAIL stall_row[%0d] got %0d/%b expected %0d/%b", i, got[i], got_last[i], e, i == 19);
            end
        end
    endtask
    task automatic test_reset_mid_row();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 8'(30 + i);
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_row_valid got %b expected 1", bus.out_valid); end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got %b/%0d/%b expected 0/0/0", bus.out_valid, bus.out_data, bus.out_last);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got %b expected 1", bus.in_ready); end
        smp[0] = 8'd5; smp[1] = 8'd6; smp[2] = 8'd7;
        lst[0] = 1'b0; lst[1] = 1'b0; lst[2] = 1'b1;
        n_in = 3;
        n_out = 3;
        do_load = 1'b0;
        run_row();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== 8'(5 + i) || got_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL post_reset_row[%0d] got %0d/%b expected %0d/%b", i, got[i], got_last[i], 5 + i, i == 2);
            end
        end
    endtask
    initial begin
        bus.cfg_load = 1'b0;
        bus.cfg_coef = ID;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_half_pel();
        test_back_to_back();
        test_clip();
        test_stall();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
